// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline definitions for hazard control: FSM encodings, register constants
// and the ID/EX control word that a bubble forces to NOP.
package hazard_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_LU  = 2'b01,
    ST_MEM = 2'b10
  } hazState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       aluSrc;
    logic [2:0] aluOp;
  } idexCtrl_t;

  // A bubble must not write registers or touch memory, so every field is zero.
  localparam idexCtrl_t NOP_CTRL = '0;

  function automatic logic isLoadUse(
    input logic       exMemRead,
    input logic [4:0] exRd,
    input logic [4:0] idRs1,
    input logic [4:0] idRs2
  );
    return exMemRead && (exRd != REG_ZERO) && ((exRd == idRs1) || (exRd == idRs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; reset outranks clear, clear outranks increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use bubbles, ID branch flushes and dcache-miss freezes,
// with saturating performance counters for each.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       idRs1_i,
  input  logic [4:0]       idRs2_i,
  input  logic             exMemRead_i,
  input  logic [4:0]       exRd_i,
  input  logic             idBranchTaken_i,
  input  logic             memStall_i,
  input  logic             cntClear_i,
  output logic             pcWrite_o,
  output logic             ifidWrite_o,
  output logic             ifidFlush_o,
  output logic             idexBubble_o,
  output logic             pipeHold_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] luStallCnt_o,
  output logic [CNT_W-1:0] flushCnt_o,
  output logic [CNT_W-1:0] missCycCnt_o
);

  hazState_t state;
  hazState_t nextState;
  logic      loadUse;

  // The instruction that was just bubbled is still in ID next cycle; masking here
  // guarantees one bubble per load-use event.
  assign loadUse = isLoadUse(exMemRead_i, exRd_i, idRs1_i, idRs2_i) && (state != ST_LU);

  // Releasing from MEM uses the same rules as RUN, so a deferred branch or
  // pending load-use acts on the very cycle memStall_i drops.
  always_comb begin
    pcWrite_o    = 1'b1;
    ifidWrite_o  = 1'b1;
    ifidFlush_o  = 1'b0;
    idexBubble_o = 1'b0;
    pipeHold_o   = 1'b0;
    nextState    = ST_RUN;
    if (memStall_i) begin
      pipeHold_o  = 1'b1;
      pcWrite_o   = 1'b0;
      ifidWrite_o = 1'b0;
      nextState   = ST_MEM;
    end else if (loadUse) begin
      pcWrite_o    = 1'b0;
      ifidWrite_o  = 1'b0;
      idexBubble_o = 1'b1;
      nextState    = ST_LU;
    end else if (idBranchTaken_i) begin
      ifidFlush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RUN;
    end else begin
      state <= nextState;
    end
  end

  assign state_o = state;

  sat_counter #(.W(CNT_W)) luStallCounter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cntClear_i),
    .inc_i (idexBubble_o),
    .cnt_o (luStallCnt_o)
  );

  sat_counter #(.W(CNT_W)) flushCounter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cntClear_i),
    .inc_i (ifidFlush_o),
    .cnt_o (flushCnt_o)
  );

  sat_counter #(.W(CNT_W)) missCycCounter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cntClear_i),
    .inc_i (pipeHold_o),
    .cnt_o (missCycCnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed vector table plus randomized run against a rule-level reference model
// for hazard_ctrl_unit; narrow counters so saturation is reachable.
module tb_hazard_ctrl_unit;

  localparam int CNT_W  = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       idRs1, idRs2, exRd;
  logic             exMemRead, idBranchTaken, memStall, cntClear;
  logic             pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold;
  logic [1:0]       state;
  logic [CNT_W-1:0] luStallCnt, flushCnt, missCycCnt;

  typedef struct {
    logic       rst;
    logic       stall;
    logic       branch;
    logic       memRead;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       clr;
    int         expWrite;
    int         expFlush;
    int         expBubble;
    int         expHold;
    int         expState;
    int         expLu;
    int         expFl;
    int         expMiss;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state: what happened last cycle, plus counter values.
  bit mPrevBubble, mPrevHold;
  int mLu, mFl, mMiss;

  hazard_ctrl_unit #(.CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .idRs1_i         (idRs1),
    .idRs2_i         (idRs2),
    .exMemRead_i     (exMemRead),
    .exRd_i          (exRd),
    .idBranchTaken_i (idBranchTaken),
    .memStall_i      (memStall),
    .cntClear_i      (cntClear),
    .pcWrite_o       (pcWrite),
    .ifidWrite_o     (ifidWrite),
    .ifidFlush_o     (ifidFlush),
    .idexBubble_o    (idexBubble),
    .pipeHold_o      (pipeHold),
    .state_o         (state),
    .luStallCnt_o    (luStallCnt),
    .flushCnt_o      (flushCnt),
    .missCycCnt_o    (missCycCnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst_, input logic stall, input logic branch, input logic memRead,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic clr,
    input int w, input int fl, input int bub, input int hold, input int st,
    input int cLu, input int cFl, input int cMiss
  );
    vec_t v;
    v.rst = rst_; v.stall = stall; v.branch = branch; v.memRead = memRead;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.clr = clr;
    v.expWrite = w; v.expFlush = fl; v.expBubble = bub; v.expHold = hold;
    v.expState = st; v.expLu = cLu; v.expFl = cFl; v.expMiss = cMiss;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst           = v.rst;
    memStall      = v.stall;
    idBranchTaken = v.branch;
    exMemRead     = v.memRead;
    exRd          = v.rd;
    idRs1         = v.rs1;
    idRs2         = v.rs2;
    cntClear      = v.clr;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Outputs follow straight from the rules: stall wins, a bubble may not follow a
  // bubble, and a branch flushes only when nothing outranks it.
  task automatic modelOutputs(input vec_t v, output vec_t e);
    bit hazard;
    e = v;
    hazard = v.memRead && (v.rd != 0) && ((v.rd == v.rs1) || (v.rd == v.rs2));
    e.expHold   = v.stall ? 1 : 0;
    e.expBubble = (!v.stall && hazard && !mPrevBubble) ? 1 : 0;
    e.expFlush  = (!v.stall && e.expBubble == 0 && v.branch) ? 1 : 0;
    e.expWrite  = (e.expHold == 0 && e.expBubble == 0) ? 1 : 0;
    e.expState  = mPrevHold ? 2 : (mPrevBubble ? 1 : 0);
    e.expLu     = mLu;
    e.expFl     = mFl;
    e.expMiss   = mMiss;
  endtask

  task automatic modelClock(input vec_t v, input vec_t e);
    if (v.rst) begin
      mPrevBubble = 0; mPrevHold = 0; mLu = 0; mFl = 0; mMiss = 0;
    end else begin
      mPrevBubble = (e.expBubble != 0);
      mPrevHold   = (e.expHold != 0);
      if (v.clr) begin
        mLu = 0; mFl = 0; mMiss = 0;
      end else begin
        if (e.expBubble != 0 && mLu < CNT_MAX) mLu++;
        if (e.expFlush != 0 && mFl < CNT_MAX) mFl++;
        if (e.expHold != 0 && mMiss < CNT_MAX) mMiss++;
      end
    end
  endtask

  task automatic step(input string tag, input vec_t v, input bit useModel);
    vec_t e, m;
    applyStimulus(v);
    @(negedge clk);
    modelOutputs(v, m);
    e = useModel ? m : v;
    checkOutput({tag, " pcWrite"}, int'(pcWrite), e.expWrite);
    checkOutput({tag, " ifidWrite"}, int'(ifidWrite), e.expWrite);
    checkOutput({tag, " ifidFlush"}, int'(ifidFlush), e.expFlush);
    checkOutput({tag, " idexBubble"}, int'(idexBubble), e.expBubble);
    checkOutput({tag, " pipeHold"}, int'(pipeHold), e.expHold);
    checkOutput({tag, " state"}, int'(state), e.expState);
    checkOutput({tag, " luStallCnt"}, int'(luStallCnt), e.expLu);
    checkOutput({tag, " flushCnt"}, int'(flushCnt), e.expFl);
    checkOutput({tag, " missCycCnt"}, int'(missCycCnt), e.expMiss);
    @(posedge clk);
    modelClock(v, m);
    #1;
  endtask

  initial begin
    vec_t v;
    // Reset with stall held, then basic pass-through.
    vecs.push_back(mk(1,1,0,0,0,1,2,0, 0,0,0,1,0, 0,0,0));
    vecs.push_back(mk(1,1,0,0,0,1,2,0, 0,0,0,1,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,0, 0,0,0));
    // Load-use on rs2; the same hazard lingering into LU gets no second bubble.
    vecs.push_back(mk(0,0,0,1,5,1,5,0, 0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,5,1,5,0, 1,0,0,0,1, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,0, 1,0,0));
    // Load to x0 is never a hazard.
    vecs.push_back(mk(0,0,0,1,0,0,2,0, 1,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,0, 1,0,0));
    // Branch with load-use: bubble first, flush next cycle.
    vecs.push_back(mk(0,0,1,1,7,7,2,0, 0,0,1,0,0, 1,0,0));
    vecs.push_back(mk(0,0,1,0,0,7,2,0, 1,1,0,0,1, 2,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,0, 2,1,0));
    // Four stall cycles with a taken branch: flush deferred to release.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,1,0,0,1,2,0, 0,0,0,1,(i == 0) ? 0 : 2, 2,1,i));
    vecs.push_back(mk(0,0,1,0,0,1,2,0, 1,1,0,0,2, 2,1,4));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,0, 2,2,4));
    // Nine stall cycles saturate the miss counter at 7.
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(0,1,0,0,0,1,2,0, 0,0,0,1,(i == 0) ? 0 : 2, 2,2,(4 + i > 7) ? 7 : 4 + i));
    // Clear during a stall wins over the increment.
    vecs.push_back(mk(0,1,0,0,0,1,2,1, 0,0,0,1,2, 2,2,7));
    vecs.push_back(mk(0,1,0,0,0,1,2,0, 0,0,0,1,2, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,2, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,0, 0,0,1));
    // Reset mid-stall returns to RUN even though the stall persists.
    vecs.push_back(mk(1,1,0,0,0,1,2,0, 0,0,0,1,0, 0,0,1));
    vecs.push_back(mk(0,1,0,0,0,1,2,0, 0,0,0,1,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,2, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,0, 0,0,1));
    // Bubble, then stall from LU, then the hazard re-fires on MEM release.
    vecs.push_back(mk(0,0,0,1,3,3,2,0, 0,0,1,0,0, 0,0,1));
    vecs.push_back(mk(0,1,0,1,3,3,2,0, 0,0,0,1,1, 1,0,1));
    vecs.push_back(mk(0,0,0,1,3,3,2,0, 0,0,1,0,2, 1,0,2));
    vecs.push_back(mk(0,0,0,0,0,1,2,0, 1,0,0,0,1, 2,0,2));

    v = mk(1,0,0,0,0,1,2,0, 0,0,0,0,0, 0,0,0);
    applyStimulus(v);
    @(posedge clk);
    mPrevBubble = 0; mPrevHold = 0; mLu = 0; mFl = 0; mMiss = 0;
    #1;

    $display("[TB] directed vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("v%0d", i), vecs[i], 1'b0);

    $display("[TB] randomized phase");
    for (int i = 0; i < 400; i++) begin
      v = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0);
      v.rst     = ($urandom_range(0, 49) == 0);
      v.stall   = ($urandom_range(0, 3) == 0);
      v.branch  = ($urandom_range(0, 2) == 0);
      v.memRead = ($urandom_range(0, 1) == 0);
      v.rd      = 5'($urandom_range(0, 3));
      v.rs1     = 5'($urandom_range(0, 3));
      v.rs2     = 5'($urandom_range(0, 3));
      v.clr     = ($urandom_range(0, 29) == 0);
      step($sformatf("r%0d", i), v, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
